// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and helpers for the memory bus arbiter.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } grant_e;

    localparam logic BUS_RD = 1'b0;
    localparam logic BUS_WR = 1'b1;

    // Round-robin pick: a lone request wins outright, a tie goes to the port not granted last.
    function automatic grant_e pick_grant(input logic if_req, input logic dm_req,
                                          input grant_e last_grant);
        if (if_req && dm_req) begin
            return (last_grant == GNT_IF) ? GNT_DM : GNT_IF;
        end else if (dm_req) begin
            return GNT_DM;
        end else begin
            return GNT_IF;
        end
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester ports plus external bus pins of the memory bus arbiter.
interface mem_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  IF_Req;
    logic [ADDR_WIDTH-1:0] IF_Addr;
    logic [DATA_WIDTH-1:0] IF_Rdata;
    logic                  IF_Ack;
    logic                  DM_Req;
    logic                  DM_We;
    logic [ADDR_WIDTH-1:0] DM_Addr;
    logic [DATA_WIDTH-1:0] DM_Wdata;
    logic [DATA_WIDTH-1:0] DM_Rdata;
    logic                  DM_Ack;
    logic [ADDR_WIDTH-1:0] ADDR;
    logic [DATA_WIDTH-1:0] Data_BUS_WRITE;
    logic [DATA_WIDTH-1:0] Data_BUS_READ;
    logic                  CS;
    logic                  WR_RD;
    logic                  Busy;

    // Arbiter side.
    modport slave (
        input  IF_Req, IF_Addr, DM_Req, DM_We, DM_Addr, DM_Wdata, Data_BUS_READ,
        output IF_Rdata, IF_Ack, DM_Rdata, DM_Ack, ADDR, Data_BUS_WRITE, CS, WR_RD, Busy
    );

    // Requester / memory side.
    modport master (
        output IF_Req, IF_Addr, DM_Req, DM_We, DM_Addr, DM_Wdata, Data_BUS_READ,
        input  IF_Rdata, IF_Ack, DM_Rdata, DM_Ack, ADDR, Data_BUS_WRITE, CS, WR_RD, Busy
    );
endinterface

// File: rtl/mem_bus_arbiter_wait_state_counter.sv
// Loadable down-counter with a zero flag; counts wait states of one bus access.
module wait_state_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load has priority; decrement saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);
endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the external memory bus between the fetch and data ports, one access at a time.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            Clk,
    input  logic            Reset,
    mem_bus_arbiter_if.slave bus
);
    // Counter only has to hold WAIT_CYCLES-1.
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

    state_e                state_q, state_d;
    grant_e                grant_q, grant_d;
    grant_e                last_grant_q, last_grant_d;
    grant_e                winner;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  cs_q, cs_d;
    logic                  wr_q, wr_d;
    logic                  if_ack_q, if_ack_d;
    logic                  dm_ack_q, dm_ack_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
    logic                  busy_q, busy_d;
    logic                  cnt_load;
    logic                  cnt_dec;
    logic                  cnt_zero;

    wait_state_counter #(.WIDTH(CNT_W)) u_wait_cnt (
        .clk      (Clk),
        .srst     (Reset),
        .load     (cnt_load),
        .load_val (LOAD_VAL),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign winner = pick_grant(bus.IF_Req, bus.DM_Req, last_grant_q);

    // Next-state and registered-output logic for the IDLE -> ACCESS -> DONE sequence.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cs_d         = cs_q;
        wr_d         = wr_q;
        if_ack_d     = 1'b0;
        dm_ack_d     = 1'b0;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        case (state_q)
            IDLE: begin
                addr_d  = '0;
                wdata_d = '0;
                cs_d    = 1'b0;
                wr_d    = BUS_RD;
                if (bus.IF_Req || bus.DM_Req) begin
                    grant_d      = winner;
                    last_grant_d = winner;
                    cs_d         = 1'b1;
                    cnt_load     = 1'b1;
                    state_d      = ACCESS;
                    if (winner == GNT_DM) begin
                        addr_d  = bus.DM_Addr;
                        wr_d    = bus.DM_We ? BUS_WR : BUS_RD;
                        wdata_d = bus.DM_We ? bus.DM_Wdata : '0;
                    end else begin
                        addr_d  = bus.IF_Addr;
                    end
                end
            end
            ACCESS: begin
                if (cnt_zero) begin
                    if (wr_q == BUS_RD) begin
                        if (grant_q == GNT_DM) begin
                            dm_rdata_d = bus.Data_BUS_READ;
                        end else begin
                            if_rdata_d = bus.Data_BUS_READ;
                        end
                    end
                    if_ack_d = (grant_q == GNT_IF);
                    dm_ack_d = (grant_q == GNT_DM);
                    addr_d   = '0;
                    wdata_d  = '0;
                    cs_d     = 1'b0;
                    wr_d     = BUS_RD;
                    state_d  = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            grant_q      <= GNT_IF;
            last_grant_q <= GNT_IF;
            addr_q       <= '0;
            wdata_q      <= '0;
            cs_q         <= 1'b0;
            wr_q         <= BUS_RD;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cs_q         <= cs_d;
            wr_q         <= wr_d;
            if_ack_q     <= if_ack_d;
            dm_ack_q     <= dm_ack_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.ADDR           = addr_q;
    assign bus.Data_BUS_WRITE = wdata_q;
    assign bus.CS             = cs_q;
    assign bus.WR_RD          = wr_q;
    assign bus.IF_Ack         = if_ack_q;
    assign bus.DM_Ack         = dm_ack_q;
    assign bus.IF_Rdata       = if_rdata_q;
    assign bus.DM_Rdata       = dm_rdata_q;
    assign bus.Busy           = busy_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random traffic against a schedule model.
module tb_mem_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int W  = 2;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    mem_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Requester agents: number of transactions each port still wants issued.
    int if_left = 0;
    int dm_left = 0;
    bit rand_mode = 1'b0;

    // Reference model: one access occupies cycles start+1 .. start+W+1.
    bit          m_active;
    int          m_start;
    bit          m_win_dm;
    bit          m_last_dm;
    bit          m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_sample;
    logic [31:0] e_if_rdata;
    logic [31:0] e_dm_rdata;
    bit          m_if_ack_prev;
    bit          m_dm_ack_prev;

    logic        obs_cs, obs_wr, obs_ifa, obs_dma, obs_busy;
    logic [31:0] obs_addr, obs_wd, obs_ifr, obs_dmr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s @cyc%0d: got %0h want %0h", tag, cyc, got, want);
        end
    endtask

    task automatic model_reset();
        m_active      = 1'b0;
        m_start       = 0;
        m_last_dm     = 1'b0;
        e_if_rdata    = '0;
        e_dm_rdata    = '0;
        m_if_ack_prev = 1'b0;
        m_dm_ack_prev = 1'b0;
        if_left       = 0;
        dm_left       = 0;
    endtask

    // Apply this cycle's inputs (called just after the rising edge).
    task automatic drive();
        if (rand_mode) Reset = ($urandom_range(0, 79) == 0);
        if (m_if_ack_prev && if_left > 0) if_left--;
        if (m_dm_ack_prev && dm_left > 0) dm_left--;
        if (rand_mode) begin
            if (if_left == 0 && $urandom_range(0, 2) == 0) begin
                if_left     = 1;
                bus.IF_Addr = $urandom;
            end
            if (dm_left == 0 && $urandom_range(0, 2) == 0) begin
                dm_left      = 1;
                bus.DM_We    = 1'($urandom_range(0, 1));
                bus.DM_Addr  = $urandom;
                bus.DM_Wdata = $urandom;
            end
            bus.Data_BUS_READ = $urandom;
        end
        bus.IF_Req = (if_left > 0);
        bus.DM_Req = (dm_left > 0);
    endtask

    // Compare every output with the model, then let the model arbitrate an idle cycle.
    task automatic check();
        logic        e_cs, e_wr, e_ifa, e_dma, e_busy;
        logic [31:0] e_addr, e_wd;
        int          d;
        obs_cs = bus.CS;   obs_wr = bus.WR_RD;  obs_ifa = bus.IF_Ack; obs_dma = bus.DM_Ack;
        obs_busy = bus.Busy; obs_addr = bus.ADDR; obs_wd = bus.Data_BUS_WRITE;
        obs_ifr = bus.IF_Rdata; obs_dmr = bus.DM_Rdata;
        e_cs = 1'b0; e_wr = 1'b0; e_ifa = 1'b0; e_dma = 1'b0; e_busy = 1'b0;
        e_addr = '0; e_wd = '0;
        if (m_active) begin
            d = cyc - m_start;
            if (d >= 1 && d <= W) begin
                e_cs = 1'b1; e_busy = 1'b1; e_addr = m_addr; e_wr = m_we;
                e_wd = m_we ? m_wdata : 32'h0;
                if (d == W) m_sample = bus.Data_BUS_READ;
            end else if (d == W + 1) begin
                e_busy = 1'b1;
                if (m_win_dm) e_dma = 1'b1; else e_ifa = 1'b1;
                if (!m_we) begin
                    if (m_win_dm) e_dm_rdata = m_sample; else e_if_rdata = m_sample;
                end
            end else begin
                m_active = 1'b0;
            end
        end
        chk("m_cs", 32'(obs_cs), 32'(e_cs));
        chk("m_wr_rd", 32'(obs_wr), 32'(e_wr));
        chk("m_addr", obs_addr, e_addr);
        chk("m_wdata", obs_wd, e_wd);
        chk("m_if_ack", 32'(obs_ifa), 32'(e_ifa));
        chk("m_dm_ack", 32'(obs_dma), 32'(e_dma));
        chk("m_if_rdata", obs_ifr, e_if_rdata);
        chk("m_dm_rdata", obs_dmr, e_dm_rdata);
        chk("m_busy", 32'(obs_busy), 32'(e_busy));
        m_if_ack_prev = e_ifa;
        m_dm_ack_prev = e_dma;
        if (Reset) begin
            model_reset();
        end else if (!m_active && (bus.IF_Req || bus.DM_Req)) begin
            if (bus.IF_Req && bus.DM_Req) m_win_dm = !m_last_dm;
            else                          m_win_dm = bus.DM_Req;
            m_last_dm = m_win_dm;
            m_active  = 1'b1;
            m_start   = cyc;
            m_we      = m_win_dm ? bus.DM_We : 1'b0;
            m_addr    = m_win_dm ? bus.DM_Addr : bus.IF_Addr;
            m_wdata   = bus.DM_Wdata;
        end
    endtask

    task automatic step();
        drive();
        @(negedge Clk);
        check();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        bus.IF_Req = 1'b0;
        bus.DM_Req = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        model_reset();
        cyc = 0;
    endtask

    initial begin
        int base;
        bus.IF_Req = 1'b0; bus.IF_Addr = '0; bus.DM_Req = 1'b0; bus.DM_We = 1'b0;
        bus.DM_Addr = '0; bus.DM_Wdata = '0; bus.Data_BUS_READ = '0;

        // Reset state with no requests.
        do_reset();
        step();
        chk("rst_cs", 32'(obs_cs), 32'd0);
        chk("rst_addr", obs_addr, 32'd0);
        chk("rst_acks", {30'd0, obs_ifa, obs_dma}, 32'd0);
        chk("rst_rdata", obs_ifr | obs_dmr, 32'd0);
        chk("rst_busy", 32'(obs_busy), 32'd0);

        // Single fetch.
        do_reset();
        bus.IF_Addr = 32'h0040_0000;
        bus.Data_BUS_READ = 32'h8C08_0004;
        if_left = 1;
        for (int c = 0; c <= 4; c++) begin
            step();
            chk("f_cs", 32'(obs_cs), 32'(c == 1 || c == 2));
            chk("f_wr_rd", 32'(obs_wr), 32'd0);
            chk("f_if_ack", 32'(obs_ifa), 32'(c == 3));
            chk("f_dm_ack", 32'(obs_dma), 32'd0);
            if (c == 1) chk("f_addr", obs_addr, 32'h0040_0000);
        end
        chk("f_if_rdata", obs_ifr, 32'h8C08_0004);

        // Data write straight after; read-data registers must hold.
        base = cyc;
        bus.DM_We = 1'b1; bus.DM_Addr = 32'h1001_0000; bus.DM_Wdata = 32'hDEAD_BEEF;
        bus.Data_BUS_READ = 32'h5555_AAAA;
        dm_left = 1;
        for (int c = 0; c <= 4; c++) begin
            step();
            chk("w_cs", 32'(obs_cs), 32'(c == 1 || c == 2));
            chk("w_wr_rd", 32'(obs_wr), 32'(c == 1 || c == 2));
            chk("w_wdata", obs_wd, (c == 1 || c == 2) ? 32'hDEAD_BEEF : 32'h0);
            chk("w_dm_ack", 32'(obs_dma), 32'(c == 3));
            chk("w_if_rdata", obs_ifr, 32'h8C08_0004);
            chk("w_dm_rdata", obs_dmr, 32'h0);
        end
        chk("w_len", 32'(cyc - base), 32'd5);

        // Simultaneous requests after reset: data port first.
        do_reset();
        bus.DM_We = 1'b0; bus.DM_Addr = 32'h1000_0040; bus.IF_Addr = 32'h0040_0010;
        if_left = 1; dm_left = 1;
        for (int c = 0; c <= 8; c++) begin
            step();
            chk("t_cs", 32'(obs_cs), 32'(c == 1 || c == 2 || c == 5 || c == 6));
            chk("t_dm_ack", 32'(obs_dma), 32'(c == 3));
            chk("t_if_ack", 32'(obs_ifa), 32'(c == 7));
            if (c == 1) chk("t_addr_dm", obs_addr, 32'h1000_0040);
            if (c == 5) chk("t_addr_if", obs_addr, 32'h0040_0010);
        end

        // Both held for four transactions: DM, IF, DM, IF.
        do_reset();
        if_left = 2; dm_left = 2;
        for (int c = 0; c <= 17; c++) begin
            step();
            chk("rr_dm_ack", 32'(obs_dma), 32'(c == 3 || c == 11));
            chk("rr_if_ack", 32'(obs_ifa), 32'(c == 7 || c == 15));
        end

        // Request withdrawn mid-access still completes.
        do_reset();
        bus.DM_We = 1'b0; bus.DM_Addr = 32'h2000_0000; bus.Data_BUS_READ = 32'h1234_5678;
        dm_left = 1;
        step();
        dm_left = 0;
        for (int c = 1; c <= 4; c++) begin
            step();
            chk("wd_cs", 32'(obs_cs), 32'(c == 1 || c == 2));
            chk("wd_dm_ack", 32'(obs_dma), 32'(c == 3));
        end
        chk("wd_dm_rdata", obs_dmr, 32'h1234_5678);

        // Reset in the middle of a data read.
        do_reset();
        bus.DM_We = 1'b0; bus.DM_Addr = 32'h3000_0000; bus.Data_BUS_READ = 32'hCAFE_F00D;
        dm_left = 1;
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            step();
            chk("mr_cs", 32'(obs_cs), 32'd0);
            chk("mr_addr", obs_addr, 32'd0);
            chk("mr_dm_ack", 32'(obs_dma), 32'd0);
            chk("mr_dm_rdata", obs_dmr, 32'd0);
            chk("mr_busy", 32'(obs_busy), 32'd0);
        end

        // Random traffic with occasional resets.
        do_reset();
        rand_mode = 1'b1;
        repeat (400) step();
        rand_mode = 1'b0;
        Reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
